vx_tex_stride_addr: RTL
=======================

Name: vx_tex_stride_addr

Overview:
Parametrised successor to the texture format-stride decoder. Decodes texel stride from format, scales per-lane texel indices into byte addresses, and serialises a NUM_LANES request into BATCH_LANES-wide responses. Skips batches with no active lanes. Sits between the texture address/wrap stage and the texture memory request unit.

Parameters:
NUM_LANES, 4, lanes per request; power of two.
BATCH_LANES, 2, lanes per response beat; power of two, divides NUM_LANES.
ADDRW, 32, byte address width.
INDEXW, 24, texel linear index width; INDEXW+3 <= ADDRW.
TAGW, 8, opaque request tag width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_format  in  3  texture format code
req_baseaddr  in  ADDRW  texture base byte address
req_mask  in  NUM_LANES  active-lane mask
req_index  in  NUM_LANES*INDEXW  per-lane texel index, lane 0 in LSBs
req_max_index  in  INDEXW  largest legal index (used only with clamp feature)
req_tag  in  TAGW  tag
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response beat consumed when valid&&ready
rsp_addr  out  BATCH_LANES*ADDRW  per-lane byte address
rsp_mask  out  BATCH_LANES  active lanes of beat
rsp_batch  out  max(1,log2(NUM_LANES/BATCH_LANES))  batch index of beat
rsp_last  out  1  final beat of request
rsp_log_stride  out  2  decoded log2 stride
rsp_oob  out  BATCH_LANES  per-lane index clamped
rsp_tag  out  TAGW  tag of request

Behaviour:
- Reset: state IDLE, rsp_valid=0, all rsp_* outputs 0, req_ready=1 in the first cycle after reset deassertion. Reset mid-request discards it; no beat emitted.
- Stride decode: 0 A8R8G8B8->2; 1 R5G6B5, 2 A1R5G5B5, 3 A4R4G4B4, 4 A8L8->1; 5 L8, 6 A8->0; 7 R16G16B16A16->3.
- Address: base + (zero-extended index << log_stride), truncated mod 2^ADDRW. Inactive lanes still compute addr; the consumer ignores them.
- FSM IDLE/BUSY. IDLE: req_ready=1. On handshake, latch the request, compute the first nonempty batch, go BUSY. rsp_valid rises the next cycle (latency 1).
- BUSY: rsp_valid=1 and output registers hold the beat. Outputs remain stable while rsp_ready=0.
- On a beat handshake with rsp_last=0, advance to the next nonempty batch in ascending order.
- On a beat handshake with rsp_last=1: if req_valid is also high, accept the new request in the same cycle and stay BUSY with no bubble. Otherwise go IDLE.
- req_ready = IDLE || (rsp_valid && rsp_last && rsp_ready).
- rsp_last is set on the highest-index nonempty batch.
- All-zero req_mask: exactly one beat with batch 0, mask 0, last=1, tag returned.
- NUM_LANES==BATCH_LANES: every request produces a single beat with rsp_batch=0.

Optional Feature:
TEX_ADDR_CLAMP_EN.
- Defined: for each lane with index > req_max_index, that index is replaced by req_max_index before scaling, and rsp_oob is set for that lane if the lane is active.
- Undefined: req_max_index is ignored and rsp_oob is constant 0.

Decomposition:
- Shared package holds: format codes and their width (3), TEX_LGSTRIDE_BITS=2, the format-to-log-stride function, and the batch count derivation.
- One sub-module, vx_tex_stride_lut: combinational format-to-log-stride decode, reused by other texture stages.
- Batch-advance logic (next nonempty batch, last detection) lives inline in the top module.

Test Plan:
- Format 0, base 0x1000, idx {1,2,3,4}, mask 1111, rsp_ready=1 -> 2 beats. Beat 0: {0x1004,0x1008}, batch 0, last 0. Beat 1: {0x100C,0x1010}, batch 1, last 1. First beat 1 cycle after accept.
- Format 7, mask 1100, idx lane2=5, lane3=6, base 0 -> single beat: batch 1, addr {0x28,0x30}, mask 11, last 1. Batch 0 is skipped.
- Mask 0000, tag 0x5A -> one beat: batch 0, mask 00, last 1, tag 0x5A.
- Hold rsp_ready=0 for 3 cycles mid-request -> outputs are stable and req_ready=0. Then issue back-to-back requests with formats 5 and 1 -> the second request is accepted on the final beat of the first, with no idle cycle.
- Assert reset while BUSY after the first beat -> rsp_valid=0 immediately, and no further beats appear after deassertion.
- With TEX_ADDR_CLAMP_EN, format 1, max 10, idx {12,3,...} -> lane0 addr = base+20, oob=1; lane1 oob=0. Without the macro, lane0 addr = base+24 and oob=0.

Source files
------------

// File: rtl/vx_tex_stride_addr_pkg.sv
// Shared texture address definitions: format codes, stride decode, batch sizing.
package vx_tex_stride_addr_pkg;

    localparam int TEX_FMT_BITS      = 3;
    localparam int TEX_LGSTRIDE_BITS = 2;

    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_A8R8G8B8     = 3'd0;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_R5G6B5       = 3'd1;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_A1R5G5B5     = 3'd2;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_A4R4G4B4     = 3'd3;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_A8L8         = 3'd4;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_L8           = 3'd5;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_A8           = 3'd6;
    localparam logic [TEX_FMT_BITS-1:0] TEX_FMT_R16G16B16A16 = 3'd7;

    function automatic logic [TEX_LGSTRIDE_BITS-1:0] tex_log_stride(
        input logic [TEX_FMT_BITS-1:0] fmt
    );
        logic [TEX_LGSTRIDE_BITS-1:0] ls;
        case (fmt)
            TEX_FMT_A8R8G8B8:     ls = 2'd2;
            TEX_FMT_R5G6B5,
            TEX_FMT_A1R5G5B5,
            TEX_FMT_A4R4G4B4,
            TEX_FMT_A8L8:         ls = 2'd1;
            TEX_FMT_R16G16B16A16: ls = 2'd3;
            default:              ls = 2'd0;
        endcase
        return ls;
    endfunction

    function automatic int tex_batch_count(input int nl, input int bl);
        return nl / bl;
    endfunction

    function automatic int tex_batch_bits(input int nl, input int bl);
        return (nl / bl > 1) ? $clog2(nl / bl) : 1;
    endfunction

endpackage

// File: rtl/vx_tex_stride_lut.sv
// Combinational texture format to log2 texel stride decode.
module vx_tex_stride_lut
    import vx_tex_stride_addr_pkg::*;
(
    input  logic [TEX_FMT_BITS-1:0]      format,
    output logic [TEX_LGSTRIDE_BITS-1:0] log_stride
);

    assign log_stride = tex_log_stride(format);

endmodule

// File: rtl/vx_tex_stride_addr.sv
// Texel index to byte address scaling with batched response serialisation.
// Optional index clamping against req_max_index: define TEX_ADDR_CLAMP_EN.
module vx_tex_stride_addr
    import vx_tex_stride_addr_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int BATCH_LANES = 2,
    parameter int ADDRW       = 32,
    parameter int INDEXW      = 24,
    parameter int TAGW        = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [2:0]                            req_format,
    input  logic [ADDRW-1:0]                      req_baseaddr,
    input  logic [NUM_LANES-1:0]                  req_mask,
    input  logic [NUM_LANES*INDEXW-1:0]           req_index,
    input  logic [INDEXW-1:0]                     req_max_index,
    input  logic [TAGW-1:0]                       req_tag,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [BATCH_LANES*ADDRW-1:0]          rsp_addr,
    output logic [BATCH_LANES-1:0]                rsp_mask,
    output logic [tex_batch_bits(NUM_LANES, BATCH_LANES)-1:0] rsp_batch,
    output logic                                  rsp_last,
    output logic [1:0]                            rsp_log_stride,
    output logic [BATCH_LANES-1:0]                rsp_oob,
    output logic [TAGW-1:0]                       rsp_tag
);

    localparam int NB = tex_batch_count(NUM_LANES, BATCH_LANES);
    localparam int BW = tex_batch_bits(NUM_LANES, BATCH_LANES);

    logic                              busy;
    logic [BW-1:0]                     cur, hi_q, first_b, hi_in, next_b;
    logic                              last_q;
    logic [NUM_LANES-1:0][ADDRW-1:0]   addr_in, addr_q;
    logic [NUM_LANES-1:0]              oob_in, oob_q, mask_q;
    logic [TAGW-1:0]                   tag_q;
    logic [1:0]                        lgs_in, lgs_q;
    logic                              req_fire, rsp_fire;

    vx_tex_stride_lut lut (
        .format     (req_format),
        .log_stride (lgs_in)
    );

    function automatic logic bnz(input logic [NUM_LANES-1:0] m, input int b);
        return |m[b*BATCH_LANES +: BATCH_LANES];
    endfunction

`ifdef TEX_ADDR_CLAMP_EN
    always_comb begin
        addr_in = '0;
        oob_in  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            logic [INDEXW-1:0] idx;
            idx = req_index[i*INDEXW +: INDEXW];
            if (idx > req_max_index) begin
                idx       = req_max_index;
                oob_in[i] = req_mask[i];
            end
            addr_in[i] = req_baseaddr + (ADDRW'(idx) << lgs_in);
        end
    end
`else
    logic unused_max;
    assign unused_max = ^req_max_index;

    always_comb begin
        addr_in = '0;
        oob_in  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            addr_in[i] = req_baseaddr
                       + (ADDRW'(req_index[i*INDEXW +: INDEXW]) << lgs_in);
        end
    end
`endif

    // An empty mask collapses to a single batch-0 beat, so both default to 0.
    always_comb begin
        first_b = '0;
        hi_in   = '0;
        for (int b = NB - 1; b >= 0; b--)
            if (bnz(req_mask, b)) first_b = BW'(b);
        for (int b = 0; b < NB; b++)
            if (bnz(req_mask, b)) hi_in = BW'(b);
    end

    always_comb begin
        next_b = cur;
        for (int b = NB - 1; b >= 0; b--)
            if (b > int'(cur) && bnz(mask_q, b)) next_b = BW'(b);
    end

    assign rsp_valid = busy;
    assign rsp_fire  = busy && rsp_ready;
    assign req_ready = !busy || (last_q && rsp_ready);
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            cur    <= '0;
            hi_q   <= '0;
            last_q <= 1'b0;
            addr_q <= '0;
            oob_q  <= '0;
            mask_q <= '0;
            tag_q  <= '0;
            lgs_q  <= '0;
        end else if (req_fire) begin
            busy   <= 1'b1;
            cur    <= first_b;
            hi_q   <= hi_in;
            last_q <= (first_b == hi_in);
            addr_q <= addr_in;
            oob_q  <= oob_in;
            mask_q <= req_mask;
            tag_q  <= req_tag;
            lgs_q  <= lgs_in;
        end else if (rsp_fire) begin
            if (last_q) begin
                busy <= 1'b0;
            end else begin
                cur    <= next_b;
                last_q <= (next_b == hi_q);
            end
        end
    end

    always_comb begin
        rsp_addr = '0;
        rsp_mask = '0;
        rsp_oob  = '0;
        for (int j = 0; j < BATCH_LANES; j++) begin
            rsp_addr[j*ADDRW +: ADDRW] = addr_q[int'(cur)*BATCH_LANES + j];
            rsp_mask[j] = mask_q[int'(cur)*BATCH_LANES + j];
            rsp_oob[j]  = oob_q[int'(cur)*BATCH_LANES + j];
        end
    end

    assign rsp_batch      = cur;
    assign rsp_last       = last_q;
    assign rsp_log_stride = lgs_q;
    assign rsp_tag        = tag_q;

endmodule
